// File: rtl/m32_uart_io_if.sv
// Core I/O port bundle between the integer core and the memory-mapped UART.
// Strobes are active-low; ioRdata is combinational and muxed into dfm upstream.
interface m32_uart_io_if;
    logic [31:0] maddr;
    logic [31:0] data2mem;
    logic        ioWr;
    logic        ioRd;
    logic [31:0] ioRdata;

    modport master (output maddr, data2mem, ioWr, ioRd, input ioRdata);
    modport slave  (input maddr, data2mem, ioWr, ioRd, output ioRdata);
endinterface

// File: rtl/m32_uart_io.sv
// Memory-mapped 8N1 UART: TX/RX FIFOs, programmable baud divisor, sticky error flags.
// Define UART_LOOPBACK_EN to add the STATUS[7] internal TX->RX loopback bit.
module m32_uart_io #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic             coreClk,
    input  logic             coreRst,
    m32_uart_io_if.slave     bus,
    output logic             uartTx,
    input  logic             uartRx,
    output logic             irq
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    localparam logic [15:0] BAUD_MIN = 16'd4;

    logic       wr_en, rd_en;
    logic [1:0] reg_sel;
    assign wr_en   = ~bus.ioWr;
    assign rd_en   = ~bus.ioRd;
    assign reg_sel = bus.maddr[3:2];

    logic unused_bits;
    assign unused_bits = ^{bus.maddr[31:4], bus.maddr[1:0], bus.data2mem[31:16]};

    logic [15:0] baud;
    logic        overrun, frame_err, loop_bit;
    logic        rx_set_ovr, rx_set_ferr;

    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [FIFO_AW:0] tx_wptr, tx_rptr;
    logic             tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [FIFO_AW:0] rx_wptr, rx_rptr;
    logic             rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0]       rx_head;

    assign tx_full  = (tx_wptr[FIFO_AW] != tx_rptr[FIFO_AW]) &&
                      (tx_wptr[FIFO_AW-1:0] == tx_rptr[FIFO_AW-1:0]);
    assign tx_empty = (tx_wptr == tx_rptr);
    assign rx_full  = (rx_wptr[FIFO_AW] != rx_rptr[FIFO_AW]) &&
                      (rx_wptr[FIFO_AW-1:0] == rx_rptr[FIFO_AW-1:0]);
    assign rx_empty = (rx_wptr == rx_rptr);

    assign tx_push = wr_en && (reg_sel == 2'd0) && !tx_full;
    assign rx_pop  = rd_en && (reg_sel == 2'd1) && !rx_empty;
    assign rx_head = rx_empty ? 8'h00 : rx_mem[rx_rptr[FIFO_AW-1:0]];

    always_ff @(posedge coreClk or negedge coreRst) begin
        if (!coreRst) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
        end
    end

    always_ff @(posedge coreClk) begin
        if (tx_push) tx_mem[tx_wptr[FIFO_AW-1:0]] <= bus.data2mem[7:0];
    end

    // Hardware error events win over a same-cycle software clear.
    always_ff @(posedge coreClk or negedge coreRst) begin
        if (!coreRst) begin
            baud      <= 16'(CLK_DIV);
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr_en && reg_sel == 2'd3)
                baud <= (bus.data2mem[15:0] < BAUD_MIN) ? BAUD_MIN : bus.data2mem[15:0];
            if (wr_en && reg_sel == 2'd2 && bus.data2mem[4]) overrun   <= 1'b0;
            if (wr_en && reg_sel == 2'd2 && bus.data2mem[5]) frame_err <= 1'b0;
            if (rx_set_ovr)  overrun   <= 1'b1;
            if (rx_set_ferr) frame_err <= 1'b1;
        end
    end

    // ---------------- transmitter ----------------
    uart_state_e tx_state, tx_next;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_shift;
    logic        tx_done, tx_serial, tx_busy;

    assign tx_done = (tx_cnt == '0);
    assign tx_busy = (tx_state != IDLE);

    always_ff @(posedge coreClk or negedge coreRst) begin
        if (!coreRst) tx_state <= IDLE;
        else          tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            IDLE:  if (!tx_empty) tx_next = START;
            START: if (tx_done) tx_next = DATA;
            DATA:  if (tx_done && tx_idx == 3'd7) tx_next = STOP;
            STOP:  if (tx_done) tx_next = tx_empty ? IDLE : START;
            default: tx_next = IDLE;
        endcase
    end

    always_comb begin
        tx_pop    = 1'b0;
        tx_serial = 1'b1;
        case (tx_state)
            IDLE:  tx_pop = !tx_empty;
            START: tx_serial = 1'b0;
            DATA:  tx_serial = tx_shift[0];
            STOP:  tx_pop = tx_done && !tx_empty;
            default: ;
        endcase
    end

    // The bit timer reloads from the live divisor so BAUD writes apply at the next bit.
    always_ff @(posedge coreClk or negedge coreRst) begin
        if (!coreRst) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
        end else if (tx_pop) begin
            tx_shift <= tx_mem[tx_rptr[FIFO_AW-1:0]];
            tx_cnt   <= baud - 16'd1;
            tx_idx   <= '0;
        end else if (tx_state != IDLE) begin
            if (tx_done) begin
                tx_cnt <= baud - 16'd1;
                if (tx_state == DATA) begin
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_idx   <= tx_idx + 1'b1;
                end
            end else begin
                tx_cnt <= tx_cnt - 16'd1;
            end
        end
    end

    // ---------------- receiver ----------------
    uart_state_e rx_state, rx_next;
    logic [1:0]  rx_sync;
    logic        rx_in, rx_line, rx_prev, rx_done;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift;

    assign rx_line = rx_sync[1];
    assign rx_done = (rx_cnt == '0);

    always_ff @(posedge coreClk or negedge coreRst) begin
        if (!coreRst) begin
            rx_sync  <= '1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
        end else begin
            rx_sync  <= {rx_sync[0], rx_in};
            rx_prev  <= rx_line;
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:  if (rx_prev && !rx_line) rx_next = START;
            START: if (rx_done) rx_next = rx_line ? IDLE : DATA;
            DATA:  if (rx_done && rx_idx == 3'd7) rx_next = STOP;
            STOP:  if (rx_done) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    always_comb begin
        rx_push     = 1'b0;
        rx_set_ferr = 1'b0;
        rx_set_ovr  = 1'b0;
        if (rx_state == STOP && rx_done) begin
            rx_set_ferr = !rx_line;
            rx_set_ovr  = rx_line && rx_full;
            rx_push     = rx_line && !rx_full;
        end
    end

    // Two cycles of edge detect precede START, so the preload is BAUD/2-2 to hit mid-bit.
    always_ff @(posedge coreClk or negedge coreRst) begin
        if (!coreRst) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                IDLE: rx_cnt <= (baud >> 1) - 16'd2;
                START, STOP: begin
                    if (rx_done) begin
                        rx_cnt <= baud - 16'd1;
                        rx_idx <= '0;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (rx_done) begin
                        rx_shift <= {rx_line, rx_shift[7:1]};
                        rx_idx   <= rx_idx + 1'b1;
                        rx_cnt   <= baud - 16'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge coreClk) begin
        if (rx_push) rx_mem[rx_wptr[FIFO_AW-1:0]] <= rx_shift;
    end

`ifdef UART_LOOPBACK_EN
    logic loopback;
    always_ff @(posedge coreClk or negedge coreRst) begin
        if (!coreRst)                       loopback <= 1'b0;
        else if (wr_en && reg_sel == 2'd2)  loopback <= bus.data2mem[7];
    end
    assign loop_bit = loopback;
    assign rx_in    = loopback ? tx_serial : uartRx;
    assign uartTx   = loopback | tx_serial;
`else
    assign loop_bit = 1'b0;
    assign rx_in    = uartRx;
    assign uartTx   = tx_serial;
`endif

    // ---------------- bus read path ----------------
    logic [7:0] status;
    assign status = {loop_bit, tx_busy, frame_err, overrun, rx_empty, rx_full, tx_empty, tx_full};
    assign irq    = !rx_empty || overrun || frame_err;

    always_comb begin
        bus.ioRdata = '0;
        if (coreRst && rd_en) begin
            case (reg_sel)
                2'd1:    bus.ioRdata = {24'h0, rx_head};
                2'd2:    bus.ioRdata = {24'h0, status};
                2'd3:    bus.ioRdata = {16'h0, baud};
                default: bus.ioRdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_m32_uart_io.sv
// Directed self-checking bench for m32_uart_io (default build, loopback disabled).
// Covers reset, TX framing, RX latency, overrun, framing error, glitch rejection, TX full drop, mid-frame reset.
module tb_m32_uart_io;
    logic coreClk = 1'b0;
    logic coreRst;
    logic uartTx, uartRx, irq;
    int   checks   = 0;
    int   failures = 0;

    localparam int unsigned RX_BIT = 4;

    m32_uart_io_if bus();

    m32_uart_io #(.CLK_DIV(16), .FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .coreClk (coreClk),
        .coreRst (coreRst),
        .bus     (bus),
        .uartTx  (uartTx),
        .uartRx  (uartRx),
        .irq     (irq)
    );

    always #5 coreClk = ~coreClk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge coreClk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [31:0] d);
        bus.maddr    = 32'hA000_0000 | {28'h0, off, 2'b00};
        bus.data2mem = d;
        bus.ioWr     = 1'b0;
        tick();
        bus.ioWr     = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] off, output logic [31:0] v);
        bus.maddr = 32'hA000_0000 | {28'h0, off, 2'b00};
        bus.ioRd  = 1'b0;
        #1;
        v = bus.ioRdata;
        tick();
        bus.ioRd  = 1'b1;
    endtask

    task automatic peek(input logic [1:0] off, output logic [31:0] v);
        bus.maddr = 32'hA000_0000 | {28'h0, off, 2'b00};
        bus.ioRd  = 1'b0;
        #1;
        v = bus.ioRdata;
        bus.ioRd  = 1'b1;
    endtask

    // Drives one frame at RX_BIT cycles/bit; st_pre is STATUS one cycle before the frame ends.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output logic [31:0] st_pre);
        uartRx = 1'b0;
        repeat (RX_BIT) tick();
        for (int i = 0; i < 8; i++) begin
            uartRx = b[i];
            repeat (RX_BIT) tick();
        end
        uartRx = stop_bit;
        repeat (RX_BIT - 1) tick();
        peek(2'd2, st_pre);
        tick();
        uartRx = 1'b1;
    endtask

    logic [31:0] v, st_pre;
    logic [7:0]  a5 = 8'hA5;
    logic [7:0]  rx_bytes [9] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h7E, 8'h24, 8'h99};
    logic [7:0]  tx_bytes [9] = '{8'h10, 8'hE7, 8'h3C, 8'h81, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h66};
    logic        exp_bit;

    initial begin
        coreRst      = 1'b0;
        uartRx       = 1'b1;
        bus.maddr    = '0;
        bus.data2mem = '0;
        bus.ioWr     = 1'b1;
        bus.ioRd     = 1'b1;
        repeat (3) tick();
        chk("rst_uartTx", {31'h0, uartTx}, 32'h1);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_ioRdata", bus.ioRdata, 32'h0);
        #2 coreRst = 1'b1;
        tick();
        peek(2'd2, v);  chk("rst_status", v, 32'h0A);
        peek(2'd3, v);  chk("rst_baud", v, 32'd16);
        peek(2'd0, v);  chk("txdata_reads_zero", v, 32'h0);

        // TX 0xA5 at 16 cycles/bit
        bus_write(2'd0, 32'h0000_00A5);
        chk("tx_idle_at_write", {31'h0, uartTx}, 32'h1);
        tick();
        chk("tx_start_first", {31'h0, uartTx}, 32'h0);
        repeat (15) tick();
        chk("tx_start_last", {31'h0, uartTx}, 32'h0);
        tick();
        chk("tx_bit0_first", {31'h0, uartTx}, 32'h1);
        repeat (8) tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tx_a5_bit%0d", i), {31'h0, uartTx}, {31'h0, a5[i]});
            repeat (16) tick();
        end
        chk("tx_stop", {31'h0, uartTx}, 32'h1);
        repeat (7) tick();
        peek(2'd2, v);  chk("tx_busy_last", v, 32'h4A);
        tick();
        peek(2'd2, v);  chk("tx_busy_clear", v, 32'h0A);

        // BAUD clamp and RX latency
        bus_write(2'd3, 32'h0000_0002);
        peek(2'd3, v);  chk("baud_clamp", v, 32'd4);
        send_frame(8'h3C, 1'b1, st_pre);
        chk("rx_lat_before", st_pre, 32'h0A);
        peek(2'd2, v);  chk("rx_lat_after", v, 32'h02);
        chk("rx_irq", {31'h0, irq}, 32'h1);
        bus_read(2'd1, v);  chk("rx_data", v, 32'h0000_003C);
        bus_read(2'd1, v);  chk("rx_empty_read", v, 32'h0);
        peek(2'd2, v);  chk("rx_status_after", v, 32'h0A);

        // Overrun: nine frames into an eight-deep FIFO
        for (int i = 0; i < 9; i++) send_frame(rx_bytes[i], 1'b1, st_pre);
        peek(2'd2, v);  chk("ovr_status", v, 32'h16);
        chk("ovr_irq", {31'h0, irq}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            bus_read(2'd1, v);
            chk($sformatf("ovr_read%0d", i), v, {24'h0, rx_bytes[i]});
        end
        peek(2'd2, v);  chk("ovr_sticky", v, 32'h1A);
        bus_write(2'd2, 32'h0000_0010);
        peek(2'd2, v);  chk("ovr_clear", v, 32'h0A);
        chk("ovr_irq_clear", {31'h0, irq}, 32'h0);

        // Framing error, then a one-cycle glitch
        send_frame(8'h55, 1'b0, st_pre);
        tick();
        peek(2'd2, v);  chk("ferr_status", v, 32'h2A);
        chk("ferr_irq", {31'h0, irq}, 32'h1);
        bus_write(2'd2, 32'h0000_0020);
        peek(2'd2, v);  chk("ferr_clear", v, 32'h0A);
        uartRx = 1'b0;
        tick();
        uartRx = 1'b1;
        repeat (30) tick();
        peek(2'd2, v);  chk("glitch_status", v, 32'h0A);
        chk("glitch_irq", {31'h0, irq}, 32'h0);

        // TX full drop: one byte goes out, then a 9-byte burst into 8 free slots
        bus_write(2'd0, 32'h0000_00C3);
        bus.maddr = 32'hA000_0000;
        for (int i = 0; i < 9; i++) begin
            bus.data2mem = {24'h0, tx_bytes[i]};
            bus.ioWr     = 1'b0;
            tick();
        end
        bus.ioWr = 1'b1;
        repeat (34) tick();
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 10; j++) begin
                if (j == 0)      exp_bit = 1'b0;
                else if (j == 9) exp_bit = 1'b1;
                else             exp_bit = tx_bytes[k][j-1];
                chk($sformatf("txburst_f%0d_b%0d", k, j), {31'h0, uartTx}, {31'h0, exp_bit});
                repeat (4) tick();
            end
        end
        chk("txburst_idle_line", {31'h0, uartTx}, 32'h1);
        peek(2'd2, v);  chk("txburst_done", v, 32'h0A);

        // Reset in the middle of a frame with bytes still queued
        bus_write(2'd0, 32'h0000_0011);
        bus_write(2'd0, 32'h0000_0022);
        bus_write(2'd0, 32'h0000_0033);
        tick();
        chk("rst_pre_low", {31'h0, uartTx}, 32'h0);
        #2 coreRst = 1'b0;
        #1;
        chk("rst_mid_uartTx", {31'h0, uartTx}, 32'h1);
        peek(2'd2, v);  chk("rst_mid_ioRdata", v, 32'h0);
        chk("rst_mid_irq", {31'h0, irq}, 32'h0);
        tick();
        #2 coreRst = 1'b1;
        tick();
        peek(2'd2, v);  chk("rst_after_status", v, 32'h0A);
        peek(2'd3, v);  chk("rst_after_baud", v, 32'd16);
        repeat (20) tick();
        chk("rst_after_line", {31'h0, uartTx}, 32'h1);
        peek(2'd2, v);  chk("rst_after_idle", v, 32'h0A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
